mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencer, sitting in EX beside the combinational ALU.
- Accepts one MDU operation per start pulse and owns the HI/LO registers.
- Holds busy for a fixed, parameterised latency so the hazard unit can stall later MDU instructions (mult/div/mfhi/mflo/mthi/mtlo).
- Result lands in HI/LO atomically on the last busy cycle.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd/msub family); legal range >=1
DIV_CYCLES, 10, busy cycles for div/divu; legal range >=1

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request qualifier; MDUOp/A/B sampled when high
MDUOp  in  4  0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd, 1000 maddu, 1001 msub, 1010 msubu
A  in  32  rs operand
B  in  32  rt operand
busy  out  1  operation in progress
done  out  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result
HI  out  32  HI register, read directly by mfhi
LO  out  32  LO register, read directly by mflo

Behaviour:
- Reset: HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0, pending result discarded. Reset overrides every other input in the same edge, including mid-operation.
- States:
  - IDLE: start with a mult/div op at edge t0 latches the result into internal pend_hi/pend_lo and loads counter = N-1 (N = MULT_CYCLES or DIV_CYCLES), then goes to BUSY.
  - BUSY: decrement counter each edge. At counter==0: HI/LO <= pend, go to IDLE, done=1 in the following cycle.
- Timing: busy=1 exactly in cycles t0+1 .. t0+N. New HI/LO and done=1 are visible in cycle t0+N+1.
- mthi/mtlo: accepted only in IDLE. HI (or LO) <= A at that edge; no busy, no done.
- Ignored requests: start while busy is ignored completely (no queueing; the hazard unit must stall). Also ignored: MDUOp=0000, any undefined code, and any MDUOp with start=0.
- mult: signed 32x32 to 64; HI = [63:32], LO = [31:0]. multu: same, unsigned.
- div: signed. LO = quotient truncated toward zero, HI = remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned. LO = A/B, HI = A%B.
- B==0 on div/divu: full busy latency still runs; HI/LO are left unchanged and done still pulses.
- Results are computed at the start edge. In-flight operands are unaffected by later changes on A/B.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - madd/maddu: {HI,LO} <= {HI,LO} + product.
  - msub/msubu: {HI,LO} <= {HI,LO} - product.
  - The {HI,LO} value used is the one at the start edge. Latency is MULT_CYCLES. All arithmetic is modulo 2^64.
- Undefined: codes 0111-1010 are treated as undefined and ignored.

Decomposition:
- Shared package/header: MDUOp code constants (MDU_NONE..MDU_MSUBU) and default latency constants. The decoder uses the same constants.
- One sub-module, mdu_arith: combinational; takes op, A, B, HI, LO and returns the 64-bit pending result plus a divide-by-zero flag.
- The FSM, counter and HI/LO registers stay in mdu_ctrl.

Test Plan:
- Reset mid-op: assert reset at t0+3 of a div. Next cycle busy=0 and HI=LO=0. No done pulse follows.
- mult timing: A=0xFFFFFFFE(-2), B=3 at t0. busy high in t0+1..t0+5. In t0+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, done=1.
- multu: same operands give HI=0x00000002, LO=0xFFFFFFFA.
- div corner cases:
  - A=-7, B=2: after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - B=0 with HI=0x11, LO=0x22: busy runs 10 cycles, then HI=0x11, LO=0x22, done=1.
- Ignore while busy: issue multu then, at t0+2, start divu and mthi A=0xDEAD. Final HI/LO hold only the multu result; busy does not extend.
- mthi/mtlo, then madd (MDU_MADD_EN):
  - mthi 0, mtlo 0xFFFFFFFF take effect next cycle with busy=0.
  - madd A=1, B=1 then gives HI=1, LO=0.
  - Without the macro, the same op leaves HI/LO unchanged and busy stays low.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - MDU opcode constants, latency defaults and op-class helpers
// Optional multiply-accumulate ops are enabled with MDU_MADD_EN.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'b0000,
        MDU_MULT  = 4'b0001,
        MDU_MULTU = 4'b0010,
        MDU_DIV   = 4'b0011,
        MDU_DIVU  = 4'b0100,
        MDU_MTHI  = 4'b0101,
        MDU_MTLO  = 4'b0110,
        MDU_MADD  = 4'b0111,
        MDU_MADDU = 4'b1000,
        MDU_MSUB  = 4'b1001,
        MDU_MSUBU = 4'b1010
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the multiplier latency; accumulate forms only exist with MDU_MADD_EN.
    function automatic logic is_mul(input logic [3:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - request/result bundle between the EX stage and the MDU
interface mdu_ctrl_if;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output start, MDUOp, A, B, input busy, done, HI, LO);
    modport slave  (input start, MDUOp, A, B, output busy, done, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational mult/div/accumulate datapath producing the pending {HI,LO}
// Accumulate ops (madd/maddu/msub/msubu) are built only with MDU_MADD_EN.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] hilo;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic [31:0] q_u;
    logic [31:0] r_u;
    logic        b_zero;

    assign hilo   = {hi, lo};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};
    assign b_zero = (b == 32'd0);

    // Signed divide on magnitudes; 0x80000000 survives as its own magnitude.
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b[31] ? (32'd0 - b) : b;
    assign q_mag = b_zero ? 32'd0 : a_mag / b_mag;
    assign r_mag = b_zero ? 32'd0 : a_mag % b_mag;
    assign q_s   = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u   = b_zero ? 32'd0 : a / b;
    assign r_u   = b_zero ? 32'd0 : a % b;

    assign div_zero = b_zero && is_div(op);

    always_comb begin
        result = hilo;
        case (op)
            MDU_MULT:  result = prod_s;
            MDU_MULTU: result = prod_u;
            MDU_DIV:   if (!b_zero) result = {r_s, q_s};
            MDU_DIVU:  if (!b_zero) result = {r_u, q_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  result = hilo + prod_s;
            MDU_MADDU: result = hilo + prod_u;
            MDU_MSUB:  result = hilo - prod_s;
            MDU_MSUBU: result = hilo - prod_u;
`endif
            default:   result = hilo;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU sequencer: busy counter, HI/LO ownership, done pulse
// Optional accumulate ops enabled by MDU_MADD_EN (see mdu_ctrl_pkg / mdu_arith).
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [31:0] MULT_LAST = 32'(MULT_CYCLES - 1);
    localparam logic [31:0] DIV_LAST  = 32'(DIV_CYCLES - 1);

    mdu_state_e  state, state_n;
    logic [31:0] cnt, cnt_n;
    logic [31:0] hi, hi_n;
    logic [31:0] lo, lo_n;
    logic [63:0] pend, pend_n;
    logic        pend_zero, pend_zero_n;
    logic        done_r, done_n;
    logic [63:0] arith_res;
    logic        arith_zero;

    mdu_arith u_arith (
        .op       (bus.MDUOp),
        .a        (bus.A),
        .b        (bus.B),
        .hi       (hi),
        .lo       (lo),
        .result   (arith_res),
        .div_zero (arith_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= 32'd0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            pend      <= 64'd0;
            pend_zero <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hi        <= hi_n;
            lo        <= lo_n;
            pend      <= pend_n;
            pend_zero <= pend_zero_n;
            done_r    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        hi_n        = hi;
        lo_n        = lo;
        pend_n      = pend;
        pend_zero_n = pend_zero;
        done_n      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_mul(bus.MDUOp) || is_div(bus.MDUOp)) begin
                        pend_n      = arith_res;
                        pend_zero_n = arith_zero;
                        cnt_n       = is_div(bus.MDUOp) ? DIV_LAST : MULT_LAST;
                        state_n     = ST_BUSY;
                    end else if (bus.MDUOp == MDU_MTHI) begin
                        hi_n = bus.A;
                    end else if (bus.MDUOp == MDU_MTLO) begin
                        lo_n = bus.A;
                    end
                end
            end
            ST_BUSY: begin
                // Requests arriving here are dropped; the hazard unit stalls on busy.
                if (cnt == 32'd0) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                    if (!pend_zero) begin
                        hi_n = pend[63:32];
                        lo_n = pend[31:0];
                    end
                end else begin
                    cnt_n = cnt - 32'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.busy = (state == ST_BUSY);
    assign bus.done = done_r;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed and random checks of mdu_ctrl against an arithmetic reference model
module tb_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_ctrl_if bus ();

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return MULT_N;
            4'd3, 4'd4: return DIV_N;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return MULT_N;
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] hilo);
        int     ia, ib, q, r;
        longint sa, sb, ua, ub;
        ia = int'(a);
        ib = int'(b);
        sa = longint'(ia);
        sb = longint'(ib);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            4'd1: return 64'(sa * sb);
            4'd2: return 64'(ua * ub);
            4'd3: begin
                if (b == 32'd0) return hilo;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = ia / ib;
                r = ia % ib;
                return {r, q};
            end
            4'd4: begin
                if (b == 32'd0) return hilo;
                return {a % b, a / b};
            end
            4'd5: return {a, hilo[31:0]};
            4'd6: return {hilo[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  return hilo + 64'(sa * sb);
            4'd8:  return hilo + 64'(ua * ub);
            4'd9:  return hilo - 64'(sa * sb);
            4'd10: return hilo - 64'(ua * ub);
`endif
            default: return hilo;
        endcase
    endfunction

    // Entered and left at a negedge; issues one request and checks the whole timeline.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          n;
        logic [63:0] exp;
        n   = lat(op);
        exp = ref_model(op, a, b, {hi_m, lo_m});
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.MDUOp = 4'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
        for (int i = 0; i < n; i++) begin
            chk("busy_in_op", 32'(bus.busy), 32'd1);
            @(negedge clk);
        end
        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("done_after", 32'(bus.done), (n > 0) ? 32'd1 : 32'd0);
        chk("hi", bus.HI, exp[63:32]);
        chk("lo", bus.LO, exp[31:0]);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        if (n > 0) begin
            @(negedge clk);
            chk("done_clear", 32'(bus.done), 32'd0);
        end
    endtask

    initial begin
        logic [63:0] exp;
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        int          seen_done;
        bus.start = 1'b0;
        bus.MDUOp = 4'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_const", bus.HI, 32'hFFFF_FFFF);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hi_const", bus.HI, 32'h0000_0002);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", bus.LO, 32'hFFFF_FFFD);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", bus.LO, 32'h8000_0000);
        run_op(4'd5, 32'h11, 32'd0);
        run_op(4'd6, 32'h22, 32'd0);
        run_op(4'd3, 32'h1234, 32'd0);
        chk("div0_hi_const", bus.HI, 32'h11);
        run_op(4'd4, 32'h1234, 32'd0);

        // Requests during busy are dropped and do not stretch the latency.
        exp = ref_model(4'd2, 32'h0001_0003, 32'h0002_0005, {hi_m, lo_m});
        bus.start = 1'b1; bus.MDUOp = 4'd2; bus.A = 32'h0001_0003; bus.B = 32'h0002_0005;
        @(negedge clk);
        bus.start = 1'b0;
        chk("ib_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.MDUOp = 4'd4; bus.A = 32'd100; bus.B = 32'd7;
        chk("ib_busy2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b1; bus.MDUOp = 4'd5; bus.A = 32'hDEAD;
        chk("ib_busy3", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("ib_busy4", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("ib_busy5", 32'(bus.busy), 32'd1);
        @(negedge clk);
        chk("ib_busy6", 32'(bus.busy), 32'd0);
        chk("ib_done", 32'(bus.done), 32'd1);
        chk("ib_hi", bus.HI, exp[63:32]);
        chk("ib_lo", bus.LO, exp[31:0]);
        hi_m = exp[63:32];
        lo_m = exp[31:0];
        @(negedge clk);
        chk("ib_busy7", 32'(bus.busy), 32'd0);
        chk("ib_done_clear", 32'(bus.done), 32'd0);

        run_op(4'd5, 32'd0, 32'd0);
        run_op(4'd6, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd7, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        chk("madd_hi_const", bus.HI, 32'd1);
`else
        chk("madd_hi_const", bus.HI, 32'd0);
`endif
        run_op(4'd0, 32'h5555, 32'h6666);
        run_op(4'd15, 32'h5555, 32'h6666);

        // Reset in the middle of a divide discards the pending result.
        bus.start = 1'b1; bus.MDUOp = 4'd4; bus.A = 32'd1000; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rm_busy1", 32'(bus.busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rm_busy", 32'(bus.busy), 32'd0);
        chk("rm_hi", bus.HI, 32'd0);
        chk("rm_lo", bus.LO, 32'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        seen_done = 0;
        for (int i = 0; i < DIV_N + 2; i++) begin
            if (bus.done) seen_done++;
            @(negedge clk);
        end
        chk("rm_no_done", 32'(seen_done), 32'd0);

        for (int k = 0; k < 40; k++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            run_op(rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
